// File: rtl/param_pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SW-bit slice is resolved per stage with the carry
// registered between stages; valid/ready on both sides, whole pipe stalls in lock-step.
module param_pipe_adder #(
   parameter int WIDTH    = 8,
   parameter int SEGMENTS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             ovf
);

   localparam int SW   = WIDTH / SEGMENTS;
   localparam int LAST = SEGMENTS - 1;

   logic [SEGMENTS-1:0]            valid_q, valid_d;
   logic [SEGMENTS-1:0]            sub_q, sub_d;
   logic [SEGMENTS-1:0]            carry_q, carry_d;
   logic [SEGMENTS-1:0][WIDTH-1:0] a_q, a_d;
   logic [SEGMENTS-1:0][WIDTH-1:0] bp_q, bp_d;
   logic [SEGMENTS-1:0][WIDTH-1:0] sum_q, sum_d;

   // What each stage sees at its input: the ports for stage 0, the previous stage otherwise.
   logic [SEGMENTS-1:0]            st_valid, st_sub, st_cin;
   logic [SEGMENTS-1:0][WIDTH-1:0] st_a, st_bp, st_sum;
   logic [SW:0]                    slice_res;
   logic                           en;

   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   always_comb begin
      st_valid  = '0;
      st_sub    = '0;
      st_cin    = '0;
      st_a      = '0;
      st_bp     = '0;
      st_sum    = '0;
      carry_d   = '0;
      slice_res = '0;

      st_valid[0] = in_valid && en;
      st_sub[0]   = sub;
      st_cin[0]   = sub;
      st_a[0]     = a;
      st_bp[0]    = sub ? ~b : b;
      for (int k = 1; k < SEGMENTS; k++) begin
         st_valid[k] = valid_q[k-1];
         st_sub[k]   = sub_q[k-1];
         st_cin[k]   = carry_q[k-1];
         st_a[k]     = a_q[k-1];
         st_bp[k]    = bp_q[k-1];
         st_sum[k]   = sum_q[k-1];
      end

      valid_d = st_valid;
      sub_d   = st_sub;
      a_d     = st_a;
      bp_d    = st_bp;
      sum_d   = st_sum;
      // Stage k only touches its own slice; lower slices arrive already resolved.
      for (int k = 0; k < SEGMENTS; k++) begin
         slice_res = {1'b0, st_a[k][k*SW +: SW]} + {1'b0, st_bp[k][k*SW +: SW]}
                   + {{SW{1'b0}}, st_cin[k]};
         sum_d[k][k*SW +: SW] = slice_res[SW-1:0];
         carry_d[k]           = slice_res[SW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         sub_q   <= '0;
         carry_q <= '0;
         a_q     <= '0;
         bp_q    <= '0;
         sum_q   <= '0;
      end else if (en) begin
         valid_q <= valid_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         bp_q    <= bp_d;
         sum_q   <= sum_d;
      end
   end

   // Top bit is carry for add and borrow for sub (borrow = no carry out of A + ~B + 1).
   assign out_valid = valid_q[LAST];
   assign result    = {carry_q[LAST] ^ sub_q[LAST], sum_q[LAST]};
   assign ovf       = (a_q[LAST][WIDTH-1] == bp_q[LAST][WIDTH-1]) &&
                      (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
